// File: rtl/seq_cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the
// internal result encoding that gets decoded into the Eq/Gt/Lt flags.
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ = 2'b00,
        RES_GT = 2'b01,
        RES_LT = 2'b10
    } res_t;

    // Returns the one-hot flag triple ordered {eq, gt, lt}
    function automatic logic [2:0] res_to_flags(input res_t res);
        logic [2:0] flags;
        case (res)
            RES_EQ:  flags = 3'b100;
            RES_GT:  flags = 3'b010;
            RES_LT:  flags = 3'b001;
            default: flags = 3'b000;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/seq_cmp_bit_cell.sv
// One-bit magnitude comparator cell; invert swaps the gt/lt decision so the
// sign bit of a two's-complement operand can be handled by the same cell.
module seq_cmp_bit_cell (
    input  logic a,
    input  logic b,
    input  logic invert,
    output logic eq,
    output logic gt,
    output logic lt
);

    logic diff;

    assign diff = a ^ b;
    assign eq   = ~diff;
    assign gt   = diff & (a ^ invert);
    assign lt   = diff & ~(a ^ invert);

endmodule

// File: rtl/seq_mag_cmp.sv
// Bit-serial MSB-first magnitude comparator with start/busy/done handshake.
// Define SEQ_CMP_SIGNED_EN to add the signed_mode port (two's-complement compare).
module seq_mag_cmp
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SEQ_CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             Eq,
    output logic             Gt,
    output logic             Lt
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [IDX_W-1:0] idx;
    logic             sgn;
    logic             invert;
    logic             cell_eq;
    logic             cell_gt;
    logic             cell_lt;
    res_t             cell_res;

`ifdef SEQ_CMP_SIGNED_EN
    logic sgn_q;
    assign sgn = sgn_q;
`else
    assign sgn = 1'b0;
`endif

    // Only the sign bit position flips the decision in signed mode
    assign invert = sgn & (idx == IDX_TOP);

    seq_cmp_bit_cell u_cell (
        .a      (a_sh[WIDTH-1]),
        .b      (b_sh[WIDTH-1]),
        .invert (invert),
        .eq     (cell_eq),
        .gt     (cell_gt),
        .lt     (cell_lt)
    );

    always_comb begin
        cell_res = RES_EQ;
        if (cell_gt) begin
            cell_res = RES_GT;
        end else if (cell_lt) begin
            cell_res = RES_LT;
        end
    end

    // Flags are only touched on the RUN->DONE edge so they survive a new start
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Eq    <= 1'b0;
            Gt    <= 1'b0;
            Lt    <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            idx   <= '0;
`ifdef SEQ_CMP_SIGNED_EN
            sgn_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        idx   <= IDX_TOP;
`ifdef SEQ_CMP_SIGNED_EN
                        sgn_q <= signed_mode;
`endif
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cell_eq && (idx != '0)) begin
                        a_sh <= {a_sh[WIDTH-2:0], 1'b0};
                        b_sh <= {b_sh[WIDTH-2:0], 1'b0};
                        idx  <= idx - 1'b1;
                    end else begin
                        {Eq, Gt, Lt} <= res_to_flags(cell_res);
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Directed self-checking bench for seq_mag_cmp (8-bit); signed vectors are
// added when SEQ_CMP_SIGNED_EN is defined.
module tb_seq_mag_cmp;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
`ifdef SEQ_CMP_SIGNED_EN
    logic       signed_mode;
`endif
    logic       busy;
    logic       done;
    logic       Eq;
    logic       Gt;
    logic       Lt;

    int vectors;
    int miscompares;
    int done_cyc;
    int busy_cyc;

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_EQ   = 3'b100;
    localparam logic [2:0] F_GT   = 3'b010;
    localparam logic [2:0] F_LT   = 3'b001;

    seq_mag_cmp #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
`ifdef SEQ_CMP_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .busy        (busy),
        .done        (done),
        .Eq          (Eq),
        .Gt          (Gt),
        .Lt          (Lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Presents operands with a one-edge start pulse; returns in cycle 1 after accept
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called in cycle 1 after accept; reports the cycle in which done shows
    task automatic waitDone(input int budget, output int dcyc, output int bcyc);
        dcyc = 0;
        bcyc = 0;
        for (int c = 1; c <= budget; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) bcyc++;
            if (done) begin
                dcyc = c;
                break;
            end
        end
    endtask

    task automatic checkAfterDone(input string tag);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        A           = 8'h00;
        B           = 8'h00;
`ifdef SEQ_CMP_SIGNED_EN
        signed_mode = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_flags", {29'd0, Eq, Gt, Lt}, {29'd0, F_NONE});
        rst = 1'b0;

        // Reset asserted while RUN is in progress aborts without a done pulse
        applyStimulus(8'h80, 8'h7F);
        checkOutput("abort_run_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("abort_done", {31'd0, done}, 32'd0);
            checkOutput("abort_busy", {31'd0, busy}, 32'd0);
            checkOutput("abort_flags", {29'd0, Eq, Gt, Lt}, {29'd0, F_NONE});
        end
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_abort_done", {31'd0, done}, 32'd0);
        checkOutput("post_abort_busy", {31'd0, busy}, 32'd0);

        // MSB differs: 0x80 > 0x7F after a single RUN cycle
        applyStimulus(8'h80, 8'h7F);
        waitDone(20, done_cyc, busy_cyc);
        checkOutput("msb_done_cyc", done_cyc, 2);
        checkOutput("msb_busy_cyc", busy_cyc, 1);
        checkOutput("msb_flags", {29'd0, Eq, Gt, Lt}, {29'd0, F_GT});
        checkAfterDone("msb");

        // Equal operands scan every bit; a start pulse mid-RUN must be ignored
        applyStimulus(8'hA5, 8'hA5);
        fork
            waitDone(20, done_cyc, busy_cyc);
            begin
                repeat (2) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        checkOutput("eq_done_cyc", done_cyc, 9);
        checkOutput("eq_busy_cyc", busy_cyc, 8);
        checkOutput("eq_flags", {29'd0, Eq, Gt, Lt}, {29'd0, F_EQ});
        checkAfterDone("eq");

        // Only LSB differs; operands wiggle during RUN without effect
        applyStimulus(8'h10, 8'h11);
        fork
            waitDone(20, done_cyc, busy_cyc);
            begin
                @(negedge clk);
                A = 8'hFF;
                B = 8'h00;
                repeat (2) @(negedge clk);
                A = 8'h00;
                B = 8'hFF;
            end
        join
        checkOutput("lsb_done_cyc", done_cyc, 9);
        checkOutput("lsb_busy_cyc", busy_cyc, 8);
        checkOutput("lsb_flags", {29'd0, Eq, Gt, Lt}, {29'd0, F_LT});
        checkAfterDone("lsb");

        // Highest difference at bit 3: 0x2C > 0x24, RUN lasts 5 cycles
        applyStimulus(8'h2C, 8'h24);
        waitDone(20, done_cyc, busy_cyc);
        checkOutput("mid_done_cyc", done_cyc, 6);
        checkOutput("mid_busy_cyc", busy_cyc, 5);
        checkOutput("mid_flags", {29'd0, Eq, Gt, Lt}, {29'd0, F_GT});
        checkAfterDone("mid");

        // Back-to-back: start held across the DONE cycle
        @(negedge clk);
        A     = 8'h03;
        B     = 8'h02;
        start = 1'b1;
        @(negedge clk);
        waitDone(20, done_cyc, busy_cyc);
        checkOutput("b2b1_done_cyc", done_cyc, 9);
        checkOutput("b2b1_flags", {29'd0, Eq, Gt, Lt}, {29'd0, F_GT});
        A = 8'h40;
        B = 8'h41;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b2_accept_busy", {31'd0, busy}, 32'd1);
        checkOutput("b2b2_accept_done", {31'd0, done}, 32'd0);
        checkOutput("b2b_flags_hold", {29'd0, Eq, Gt, Lt}, {29'd0, F_GT});
        waitDone(20, done_cyc, busy_cyc);
        checkOutput("b2b2_done_cyc", done_cyc, 9);
        checkOutput("b2b2_busy_cyc", busy_cyc, 8);
        checkOutput("b2b2_flags", {29'd0, Eq, Gt, Lt}, {29'd0, F_LT});
        checkAfterDone("b2b2");

`ifdef SEQ_CMP_SIGNED_EN
        // Signed: 0x80 is -128, below 0x01
        signed_mode = 1'b1;
        applyStimulus(8'h80, 8'h01);
        waitDone(20, done_cyc, busy_cyc);
        checkOutput("sgn_done_cyc", done_cyc, 2);
        checkOutput("sgn_flags", {29'd0, Eq, Gt, Lt}, {29'd0, F_LT});
        checkAfterDone("sgn");

        // Signed mode with a lower-bit difference behaves as unsigned
        applyStimulus(8'hF3, 8'hF1);
        waitDone(20, done_cyc, busy_cyc);
        checkOutput("sgn_low_done_cyc", done_cyc, 8);
        checkOutput("sgn_low_flags", {29'd0, Eq, Gt, Lt}, {29'd0, F_GT});
        checkAfterDone("sgn_low");

        signed_mode = 1'b0;
        applyStimulus(8'h80, 8'h01);
        waitDone(20, done_cyc, busy_cyc);
        checkOutput("uns_done_cyc", done_cyc, 2);
        checkOutput("uns_flags", {29'd0, Eq, Gt, Lt}, {29'd0, F_GT});
        checkAfterDone("uns");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
